// File: rtl/multicycle_adder_if.sv
// Handshake bundle for multicycle_adder: operand request channel and result channel.
interface multicycle_adder_if #(
    parameter int unsigned WIDTH = 8
);
    // Request channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Status
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor. Resolves WIDTH-bit operands DIGIT bits per clock,
// LSB digit first, through a registered carry. Subtraction is A + ~B + ~cin.
module multicycle_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_adder_if.slave  bus
);
    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned KW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for subtraction
    logic [WIDTH-1:0] acc_q;    // partial result being assembled
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             in_ready_q;

    int unsigned      idx;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_sum;
    logic [WIDTH-1:0] acc_d;
    logic             ovf_d;
    logic             last_step;

    // Digit adder for the current step plus the result it would produce if this is the last step
    always_comb begin
        idx       = DIGIT * 32'(k_q);
        a_dig     = a_q[idx +: DIGIT];
        b_dig     = b_q[idx +: DIGIT];
        dig_sum   = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        acc_d     = acc_q;
        acc_d[idx +: DIGIT] = dig_sum[DIGIT-1:0];
        // a^b^sum at the MSB recovers the carry into the MSB; xor with carry out gives overflow
        ovf_d     = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_d[WIDTH-1] ^ dig_sum[DIGIT];
        last_step = (k_q == KW'(STEPS - 1));
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.sub ? ~bus.b : bus.b;
                        carry_q    <= bus.cin ^ bus.sub;
                        k_q        <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    acc_q   <= acc_d;
                    carry_q <= dig_sum[DIGIT];
                    k_q     <= k_q + KW'(1);
                    if (last_step) begin
                        k_q         <= '0;
                        sum_q       <= acc_d;
                        cout_q      <= dig_sum[DIGIT];
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // Results stay loaded after the handshake until the next completion
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs come straight from registers; in_ready is also masked by reset
    always_comb begin
        bus.in_ready  = in_ready_q & ~rst;
        bus.out_valid = out_valid_q;
        bus.sum       = sum_q;
        bus.cout      = cout_q;
        bus.ovf       = ovf_q;
        bus.busy      = busy_q;
    end
endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit full adder. It accepts two WIDTH-bit operands over a valid/ready handshake and resolves them DIGIT bits per clock, LSB digit first, through a registered carry chain. It returns sum, carry-out and signed overflow over a second valid/ready handshake. It sits behind the Tiny Tapeout user wrapper, which maps the ports onto ui_in/uio/uo_out.

## Interface
- WIDTH, 8: operand and result width; must be ≥ 2.
- DIGIT, 1: bits resolved per cycle; must divide WIDTH (DIGIT = WIDTH is legal). STEPS = WIDTH/DIGIT.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/mode present.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin, 1 = A−B−cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, capture a, b_eff = sub ? ~b : b, and c0 = cin ^ sub. Clear the step counter and go to RUN.
  - RUN: each cycle add digit k of a, digit k of b_eff and the carry register. Store the DIGIT result bits at position k, update carry, k += 1. On the cycle with k = STEPS−1, go to DONE.
  - DONE: out_valid = 1. On out_valid & out_ready, go to IDLE.
- sum, cout and ovf are output registers loaded only on the edge entering DONE. They hold their value at all other times, including after returning to IDLE, until the next completion.
- ovf = carry into MSB XOR carry out of MSB.
- in_ready is low in RUN and DONE. in_valid in those states is ignored; no operand is queued or lost silently (the producer holds it).
- in_ready = (state == IDLE) & ~rst.
- Backpressure: in DONE with out_ready = 0, all outputs are held stable indefinitely.
- Reset, asynchronous, at any time including mid-RUN or in DONE:
  - state = IDLE, counter = 0, carry = 0.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0, busy = 0.
  - The in-flight operation is discarded.

## Timing
- Accept edge = edge T where in_valid & in_ready are sampled high.
- RUN occupies edges T+1 … T+STEPS. out_valid is high after edge T+STEPS.
  - Latency: STEPS cycles accept-to-valid (8 for WIDTH=8, DIGIT=1; 2 for DIGIT=4; 1 for DIGIT=WIDTH).
- An output handshake at edge U returns to IDLE. in_ready is high after U. The next accept is earliest at U+1.
- Peak throughput: one operation per STEPS+2 cycles.
- No combinational path from in_valid or out_ready to any output except through state.

## Test plan
- Reset:
  - Assert rst for 3 cycles during RUN, WIDTH=8 DIGIT=1.
  - Required: sum=00, cout=0, ovf=0, out_valid=0, busy=0 immediately (asynchronous).
  - Required: in_ready=1 on the first cycle after release; no stale result appears later.
- Signed overflow add, WIDTH=8 DIGIT=1:
  - Stimulus: a=7F, b=01, cin=0, sub=0.
  - Required: out_valid exactly 8 cycles after accept; sum=80, cout=0, ovf=1.
- Wrap with carry-in:
  - Stimulus: a=FF, b=01, cin=1, sub=0.
  - Required: sum=01, cout=1, ovf=0.
- Subtract with borrow:
  - Stimulus: a=00, b=01, sub=1, cin=0.
  - Required: sum=FF, cout=0, ovf=0.
  - Stimulus: a=80, b=01, sub=1, cin=0.
  - Required: sum=7F, cout=1, ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid; pulse in_valid with new operands during that time.
  - Required: out_valid, sum, cout and ovf remain stable; in_ready=0; the new operands are not captured.
  - After out_ready=1 for one edge: in_ready=1 next cycle.
- DIGIT=4, WIDTH=8:
  - Stimulus: a=3C, b=C5, cin=1, sub=0, followed immediately by a second operation.
  - Required: out_valid 2 cycles after accept; sum=02, cout=1, ovf=0.
  - Required: the second operation is accepted no earlier than one cycle after the output handshake.
